// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drives a registered-read FIFO and re-presents its words as a
// valid/ready stream via a 2-entry skid buffer. Optional counters: FIFO_STREAM_STATS_EN.
module fifo_stream_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_STREAM_STATS_EN
    ,
    output logic [31:0]      xfer_count,
    output logic [31:0]      stall_count
`endif
);

    logic             pend;
    logic [1:0]       occ;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] mem_q [2];
    logic             pop;
    logic [2:0]       fill_next;

    assign pop       = m_valid && m_ready;
    // Never underflows: pop implies occ >= 1.
    assign fill_next = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    // Issue only if the word landing next cycle is guaranteed a free slot.
    assign fifo_rd_en = rst_n && !fifo_empty && (fill_next < 3'd2);

    assign m_valid = (occ != 2'd0);
    assign m_data  = mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            pend <= fifo_rd_en;
            occ  <= fill_next[1:0];
            // Capture only on the cycle after an issued read; stale rd_data is ignored.
            if (pend) begin
                mem_q[wr_ptr] <= fifo_rd_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

`ifdef FIFO_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count  <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (pop)
                xfer_count <= xfer_count + 32'd1;
            if (m_valid && !m_ready && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

`ifdef ASSERT_ON
    always @(posedge clk) begin
        if (rst_n)
            assert (!(pend && (occ == 2'd2) && !pop));
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO model.
module tb_fifo_stream_reader;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_rd_data = '0;
    logic         fifo_empty;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready = 1'b0;
`ifdef FIFO_STREAM_STATS_EN
    logic [31:0]  xfer_count;
    logic [31:0]  stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready)
`ifdef FIFO_STREAM_STATS_EN
        ,
        .xfer_count   (xfer_count),
        .stall_count  (stall_count)
`endif
    );

    // FIFO model: registered read, write side fed directly by the stimulus.
    logic [W-1:0] fmem [0:4095];
    int wr_idx = 0;
    int rd_idx = 0;
    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_idx <= 0;
        else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        wr_idx  = 0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // A read must never be issued into an empty FIFO.
    always @(negedge clk) begin
        #3;
        if (rst_n) check("rd_en_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] sb [$];
        int t, reads, exp_i, pushed, n;
        logic [W-1:0] w;

        // Reset state
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // Basic latency
        @(negedge clk);
        m_ready = 1'b1;
        push(8'hA5);
        #1;
        check("lat_c0_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        check("lat_c0_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk); #1;
        check("lat_c1_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("lat_c1_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk); #1;
        check("lat_c2_valid", {31'd0, m_valid}, 32'd1);
        check("lat_c2_data", {24'd0, m_data}, 32'hA5);
        @(negedge clk); #1;
        check("lat_c3_valid", {31'd0, m_valid}, 32'd0);
`ifdef FIFO_STREAM_STATS_EN
        check("lat_xfer", xfer_count, 32'd1);
`endif

        // Streaming, 16 pre-filled words
        do_reset();
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(W'(i));
        #1;
        t = 0;
        while (!m_valid && t < 10) begin
            @(negedge clk); #1;
            t++;
        end
        check("stream_first_lat", t, 32'd2);
        for (int i = 0; i < 16; i++) begin
            check("stream_valid", {31'd0, m_valid}, 32'd1);
            check("stream_data", {24'd0, m_data}, i);
            @(negedge clk); #1;
        end
        check("stream_end_valid", {31'd0, m_valid}, 32'd0);
        check("stream_end_empty", {31'd0, fifo_empty}, 32'd1);
`ifdef FIFO_STREAM_STATS_EN
        check("stream_xfer", xfer_count, 32'd16);
        check("stream_stall", stall_count, 32'd0);
`endif

        // Back-pressure: ready low for 12 cycles, valid high for the last 10
        do_reset();
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(W'(i));
        #1;
        reads = 0;
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) begin
                check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
                check("bp_hold_data", {24'd0, m_data}, 32'h00);
            end
            reads += int'(fifo_rd_en);
            @(negedge clk); #1;
        end
        check("bp_reads", reads, 32'd2);
        m_ready = 1'b1;
        #1 check("bp_resume_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("bp_valid", {31'd0, m_valid}, 32'd1);
            check("bp_data", {24'd0, m_data}, i);
            @(negedge clk); #2;
        end
        check("bp_end_valid", {31'd0, m_valid}, 32'd0);
`ifdef FIFO_STREAM_STATS_EN
        check("bp_stall", stall_count, 32'd10);
        check("bp_xfer", xfer_count, 32'd16);
`endif

        // Random handshake with scoreboard
        do_reset();
        exp_i  = 0;
        pushed = 0;
        t      = 0;
        while (exp_i < 1000 && t < 20000) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                w = W'($urandom);
                push(w);
                sb.push_back(w);
                pushed++;
            end
            #1;
            if (m_valid && m_ready) begin
                check("rand_data", {24'd0, m_data}, {24'd0, sb[exp_i]});
                exp_i++;
            end
            t++;
        end
        check("rand_count", exp_i, 32'd1000);
        @(negedge clk);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("rand_no_extra", {31'd0, m_valid}, 32'd0);

        // Asynchronous reset mid-transfer with a full skid buffer
        do_reset();
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(W'(8'h55 + i));
        repeat (4) @(negedge clk);
        #1;
        check("mid_pre_valid", {31'd0, m_valid}, 32'd1);
        check("mid_pre_data", {24'd0, m_data}, 32'h55);
        m_ready = 1'b1;
        #1 check("mid_pre_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        rst_n  = 1'b0;
        wr_idx = 0;
        #1;
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_data", {24'd0, m_data}, 32'd0);
        check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(8'h3C);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (m_valid && m_ready) begin
                check("mid_post_data", {24'd0, m_data}, 32'h3C);
                n++;
            end
            @(negedge clk);
        end
        check("mid_post_count", n, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
